// File: rtl/encoder8_3_seq.sv
// rtl/encoder8_3_seq.sv - sequential 8-to-3 encoder, one index per beat, highest set bit first
// Serialises a captured request vector into the indices of its set bits.

module encoder8_3_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] d,
  output logic [2:0] y,
  output logic       y_valid,
  input  logic       y_ready,
  output logic       y_last,
  output logic       none,
  output logic [3:0] count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [7:0] pending;
  logic [2:0] hi_idx;
  logic       single_bit;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // Ascending scan so the highest set bit wins.
  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) hi_idx = 3'(i);
    end
  end

  assign single_bit = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);

  // All outputs decode from state and registers only.
  assign in_ready = (state == IDLE);
  assign y_valid  = (state == BUSY);
  assign y        = (state == BUSY) ? hi_idx : 3'd0;
  assign y_last   = (state == BUSY) && (none || single_bit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 8'd0;
      count   <= 4'd0;
      none    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pending <= d;
            count   <= popcount8(d);
            none    <= (d == 8'd0);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (y_ready) begin
            pending <= pending & ~(8'd1 << y);
            if (y_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder8_3_seq.sv
// tb/tb_encoder8_3_seq.sv - scoreboard bench for encoder8_3_seq
// Expected beats are queued at capture and popped on each accepted output beat.

module tb_encoder8_3_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic [2:0] y;
  logic       y_valid;
  logic       y_ready;
  logic       y_last;
  logic       none;
  logic [3:0] count;

  encoder8_3_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_last   (y_last),
    .none     (none),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] y;
    logic       last;
    logic       none;
    logic [3:0] count;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    int         beats;
    int         cycles;
    logic [3:0] cnt;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  beat_t      q[$];
  beat_t      e;
  logic [7:0] cap_d = 8'd0;
  logic [7:0] or_acc = 8'd0;
  int         beats_seen = 0;
  logic       expect_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: indices of set bits from 7 down to 0.
  task automatic push_expected(input logic [7:0] v);
    int n;
    int rem;
    beat_t b;
    n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    if (v == 8'd0) begin
      b.y = 3'd0; b.last = 1'b1; b.none = 1'b1; b.count = 4'd0;
      q.push_back(b);
    end else begin
      rem = n;
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) begin
          rem--;
          b.y = 3'(i); b.last = (rem == 0); b.none = 1'b0; b.count = 4'(n);
          q.push_back(b);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      expect_valid = 1'b0;
    end else begin
      chk("in_ready_vs_y_valid", {31'd0, in_ready}, {31'd0, !y_valid});
      if (expect_valid) chk("first_beat_latency", {31'd0, y_valid}, 32'd1);
      expect_valid = 1'b0;
      if (y_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = q[0];
          chk("y", {29'd0, y}, {29'd0, e.y});
          chk("y_last", {31'd0, y_last}, {31'd0, e.last});
          chk("none", {31'd0, none}, {31'd0, e.none});
          chk("count", {28'd0, count}, {28'd0, e.count});
          if (y_ready) begin
            void'(q.pop_front());
            beats_seen++;
            if (!none) or_acc = or_acc | (8'd1 << y);
            if (y_last) chk("decoder_or", {24'd0, or_acc}, {24'd0, cap_d});
          end
        end
      end
      if (in_valid && in_ready) begin
        cap_d = d;
        or_acc = 8'd0;
        beats_seen = 0;
        expect_valid = 1'b1;
        push_expected(d);
      end
    end
  end

  // Returns at posedge+1 of the capture edge.
  task automatic capture(input logic [7:0] v);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    d = v;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) chk("capture_timeout", 32'd0, 32'd1);
  endtask

  // mode 0: y_ready held high; mode 1: y_ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, output int cycles);
    logic done;
    done = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      y_ready = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
      @(negedge clk);
      cycles++;
      if (!y_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    y_ready = 1'b1;
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  vec_t tbl[7];
  int   cyc;
  int   n;
  logic got;

  initial begin
    tbl[0] = '{d: 8'h01, beats: 1, cycles: 2, cnt: 4'd1};
    tbl[1] = '{d: 8'hA5, beats: 4, cycles: 5, cnt: 4'd4};
    tbl[2] = '{d: 8'h00, beats: 1, cycles: 2, cnt: 4'd0};
    tbl[3] = '{d: 8'h80, beats: 1, cycles: 2, cnt: 4'd1};
    tbl[4] = '{d: 8'h3C, beats: 4, cycles: 5, cnt: 4'd4};
    tbl[5] = '{d: 8'hFF, beats: 8, cycles: 9, cnt: 4'd8};
    tbl[6] = '{d: 8'h18, beats: 2, cycles: 3, cnt: 4'd2};

    rst_n = 1'b0;
    in_valid = 1'b0;
    y_ready = 1'b0;
    d = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_y", {29'd0, y}, 32'd0);
    chk("rst_y_last", {31'd0, y_last}, 32'd0);
    chk("rst_none", {31'd0, none}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    @(posedge clk);
    #1;
    y_ready = 1'b1;

    for (int t = 0; t < 7; t++) begin
      capture(tbl[t].d);
      drain(0, cyc);
      chk("vec_cycles", cyc, tbl[t].cycles);
      chk("vec_beats", beats_seen, tbl[t].beats);
      chk("vec_queue_empty", q.size(), 0);
      chk("vec_count_held", {28'd0, count}, {28'd0, tbl[t].cnt});
    end

    // Backpressure: 0xFF with y_ready 1,0,0,...
    capture(8'hFF);
    drain(1, cyc);
    chk("stall_beats", beats_seen, 8);
    chk("stall_queue_empty", q.size(), 0);
    chk("stall_count", {28'd0, count}, 32'd8);

    // Second vector offered during BUSY is taken at the first IDLE edge.
    capture(8'h81);
    in_valid = 1'b1;
    d = 8'h7E;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("busy_ignore_gap", n, 3);
    drain(0, cyc);
    chk("second_vec_beats", beats_seen, 6);
    chk("second_vec_cycles", cyc, 7);
    chk("second_vec_queue_empty", q.size(), 0);

    // Reset after the first beat of 0xF0 discards the rest.
    capture(8'hF0);
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_beats_before", beats_seen, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_y_valid", {31'd0, y_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_count", {28'd0, count}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("mid_rst_beats_after", beats_seen, 1);

    capture(8'h02);
    drain(0, cyc);
    chk("post_rst_beats", beats_seen, 1);
    chk("post_rst_cycles", cyc, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder8_3_seq.md
# encoder8_3_seq

Sequential 8-to-3 encoder: the return path for our 3-to-8 decoder. It accepts an 8-bit request vector over a valid/ready handshake and emits the 3-bit index of every set bit, one index per accepted output beat, highest index first. Feeding each emitted index into the 3-to-8 decoder regenerates the corresponding one-hot bit, so a decoder/encoder pair round-trips any vector. Typical uses are request-to-index conversion and interrupt/event serialisation ahead of index-driven logic.

## Interface
Parameters: none. Widths are fixed at 8 to 3.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  d is valid this cycle.
- in_ready  out  1  block can accept d this cycle.
- d  in  8  request vector.
- y  out  3  index of the current set bit.
- y_valid  out  1  y, y_last and none are valid.
- y_ready  in  1  consumer accepts the current beat.
- y_last  out  1  current beat is the final beat for the captured vector.
- none  out  1  captured vector was all zeros; y=0 on that beat.
- count  out  4  popcount of the captured vector, 0..8, held until the next capture.

## Operation
- States: IDLE and BUSY. State, the pending vector (8b), the none flag and count are registers. y, y_valid and y_last are decoded from registers only, with no combinational path from any input.
- IDLE:
  - in_ready=1, y_valid=0.
  - On in_valid&in_ready: pending<=d, count<=popcount(d), none<=(d==0), go to BUSY.
- BUSY:
  - in_ready=0, y_valid=1.
  - If pending!=0: y = index of the highest set bit of pending (bit 7 has top priority), none=0, y_last=(popcount(pending)==1).
  - If the captured d was 0 (single beat): y=0, none=1, y_last=1.
- On y_valid&y_ready in BUSY:
  - Clear bit y of pending.
  - If y_last, go to IDLE.
  - On a zero-vector beat, pending stays 0 and the state goes to IDLE.
- Backpressure: while y_valid&!y_ready, y, y_last, none, count and pending hold.
- in_valid in BUSY is ignored; d is not sampled.
- count is unchanged by output beats and is updated only on capture.

Reset (rst_n=0 at a rising edge):
- state=IDLE, pending=0, count=0, none=0.
- Resulting outputs: in_ready=1, y_valid=0, y=0, y_last=0.
- Reset mid-BUSY discards the remaining indices with no further beats.
- Reset has priority over a simultaneous handshake.

## Timing
- Capture at edge N: y_valid=1 from cycle N+1, with the first index presented in that cycle.
- With y_ready held at 1, a vector with k set bits produces k beats on consecutive cycles, N+1..N+k. A zero vector produces exactly 1 beat.
- The last beat accepted at edge M returns the block to IDLE, so in_ready=1 in cycle M+1. The earliest next capture is edge M+1.
- Sustained rate is k+1 cycles per vector of k≥1 bits.
- in_ready depends on state only. y_valid never drops without a handshake, except under reset.
- A stall of any length under y_ready=0 loses no indices and creates no duplicates.

## Test plan
- Reset, then d=8'b0000_0001 accepted with y_ready=1: one beat y=0, y_last=1, none=0, count=1. in_ready is back to 1 in the next cycle.
- d=8'b1010_0101 with y_ready=1: beats y=7,5,2,0 on 4 consecutive cycles, y_last only on y=0, count=4. Route each y through the 3-to-8 decoder and OR the results: the OR equals 8'hA5.
- d=8'h00: single beat y=0, none=1, y_last=1, count=0.
- d=8'hFF with y_ready toggling 1,0,0,1,...: exactly 8 beats 7..0 in order. Outputs are stable during each stall, with no repeats or skips. count=8.
- d=8'h81 captured, then in_valid=1 with d=8'h7E during BUSY: the second vector is ignored until IDLE. Output is y=7 then y=0. d=8'h7E is then captured at the first IDLE edge and yields 6,5,4,3,2,1.
- d=8'hF0 captured, rst_n=0 after the first beat (y=7): y_valid=0 and in_ready=1 after the reset edge. The remaining indices 6,5,4 are never emitted, and count=0.
